// File: rtl/reorder_buffer.sv
// In-order reorder buffer: multi-lane dispatch, out-of-order completion,
// registered in-order retire of up to RETIRE_W contiguous completed entries per cycle.
module reorder_buffer #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int COMPLETE_W = 3,
  parameter int RETIRE_W   = 2,
  parameter int PC_W       = 32,
  parameter int PREG_W     = 6,
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  localparam int TAG_W     = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [DISPATCH_W-1:0]                dispatch_valid,
  input  logic [DISPATCH_W-1:0][PC_W-1:0]      dispatch_pc,
  input  logic [DISPATCH_W-1:0][PREG_W-1:0]    dispatch_rd,
  input  logic [DISPATCH_W-1:0][PREG_W-1:0]    dispatch_rd_old,
  input  logic [DISPATCH_W-1:0][CTRL_W-1:0]    dispatch_ctrl,
  output logic                                 dispatch_ready,
  output logic [DISPATCH_W-1:0][TAG_W-1:0]     dispatch_rob_num,
  input  logic [COMPLETE_W-1:0]                complete_valid,
  input  logic [COMPLETE_W-1:0][TAG_W-1:0]     complete_rob_num,
  input  logic [COMPLETE_W-1:0][DATA_W-1:0]    complete_result,
  input  logic [COMPLETE_W-1:0][DATA_W-1:0]    complete_wr_data,
  output logic [RETIRE_W-1:0]                  retire_valid,
  output logic [RETIRE_W-1:0][PC_W-1:0]        retire_pc,
  output logic [RETIRE_W-1:0][PREG_W-1:0]      retire_rd,
  output logic [RETIRE_W-1:0][PREG_W-1:0]      retire_rd_old,
  output logic [RETIRE_W-1:0][CTRL_W-1:0]      retire_ctrl,
  output logic [RETIRE_W-1:0][DATA_W-1:0]      retire_result,
  output logic [RETIRE_W-1:0][DATA_W-1:0]      retire_wr_data,
  output logic [TAG_W:0]                       count,
  output logic                                 full,
  output logic                                 empty
);

  localparam logic [TAG_W:0] PTR_ONE   = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] READY_MAX = (TAG_W+1)'(DEPTH - DISPATCH_W);
  localparam logic [TAG_W:0] FULL_CNT  = (TAG_W+1)'(DEPTH);

  logic [TAG_W:0] head, tail;
  logic [DEPTH-1:0]             ent_valid, ent_done;
  logic [DEPTH-1:0][PC_W-1:0]   ent_pc;
  logic [DEPTH-1:0][PREG_W-1:0] ent_rd, ent_rd_old;
  logic [DEPTH-1:0][CTRL_W-1:0] ent_ctrl;
  logic [DEPTH-1:0][DATA_W-1:0] ent_result, ent_wr_data;

  logic [TAG_W:0]                disp_n, ret_n;
  logic [RETIRE_W-1:0]           ret_sel;
  logic [RETIRE_W-1:0][TAG_W-1:0] ret_idx;
  logic                          chain;

  assign count          = tail - head;
  assign full           = (count == FULL_CNT);
  assign empty          = (count == '0);
  // Credit comes from the registered count only; same-cycle retires are not counted.
  assign dispatch_ready = (count <= READY_MAX);

  always_comb begin
    disp_n = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      dispatch_rob_num[i] = tail[TAG_W-1:0] + TAG_W'(i);
      if (dispatch_valid[i]) disp_n = disp_n + PTR_ONE;
    end
  end

  // Retire selection uses registered complete bits, so a completion never bypasses.
  always_comb begin
    ret_sel = '0;
    ret_idx = '0;
    ret_n   = '0;
    chain   = 1'b1;
    for (int k = 0; k < RETIRE_W; k++) begin
      ret_idx[k] = head[TAG_W-1:0] + TAG_W'(k);
      chain      = chain && ent_valid[ret_idx[k]] && ent_done[ret_idx[k]];
      ret_sel[k] = chain;
      if (chain) ret_n = ret_n + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head           <= '0;
      tail           <= '0;
      ent_valid      <= '0;
      ent_done       <= '0;
      ent_pc         <= '0;
      ent_rd         <= '0;
      ent_rd_old     <= '0;
      ent_ctrl       <= '0;
      ent_result     <= '0;
      ent_wr_data    <= '0;
      retire_valid   <= '0;
      retire_pc      <= '0;
      retire_rd      <= '0;
      retire_rd_old  <= '0;
      retire_ctrl    <= '0;
      retire_result  <= '0;
      retire_wr_data <= '0;
    end else if (flush) begin
      head           <= '0;
      tail           <= '0;
      ent_valid      <= '0;
      ent_done       <= '0;
      ent_pc         <= '0;
      ent_rd         <= '0;
      ent_rd_old     <= '0;
      ent_ctrl       <= '0;
      ent_result     <= '0;
      ent_wr_data    <= '0;
      retire_valid   <= '0;
      retire_pc      <= '0;
      retire_rd      <= '0;
      retire_rd_old  <= '0;
      retire_ctrl    <= '0;
      retire_result  <= '0;
      retire_wr_data <= '0;
    end else begin
      // Highest port first so the lowest-numbered port's write lands last and wins.
      for (int p = COMPLETE_W - 1; p >= 0; p--) begin
        if (complete_valid[p] && ent_valid[complete_rob_num[p]]) begin
          ent_done[complete_rob_num[p]]    <= 1'b1;
          ent_result[complete_rob_num[p]]  <= complete_result[p];
          ent_wr_data[complete_rob_num[p]] <= complete_wr_data[p];
        end
      end

      if (dispatch_ready) begin
        for (int i = 0; i < DISPATCH_W; i++) begin
          if (dispatch_valid[i]) begin
            ent_valid[dispatch_rob_num[i]]   <= 1'b1;
            ent_done[dispatch_rob_num[i]]    <= 1'b0;
            ent_pc[dispatch_rob_num[i]]      <= dispatch_pc[i];
            ent_rd[dispatch_rob_num[i]]      <= dispatch_rd[i];
            ent_rd_old[dispatch_rob_num[i]]  <= dispatch_rd_old[i];
            ent_ctrl[dispatch_rob_num[i]]    <= dispatch_ctrl[i];
            ent_result[dispatch_rob_num[i]]  <= '0;
            ent_wr_data[dispatch_rob_num[i]] <= '0;
          end
        end
        tail <= tail + disp_n;
      end

      // Retiring entries are distinct from free dispatch slots, so clears never collide.
      for (int k = 0; k < RETIRE_W; k++) begin
        retire_valid[k]   <= ret_sel[k];
        retire_pc[k]      <= ret_sel[k] ? ent_pc[ret_idx[k]]      : '0;
        retire_rd[k]      <= ret_sel[k] ? ent_rd[ret_idx[k]]      : '0;
        retire_rd_old[k]  <= ret_sel[k] ? ent_rd_old[ret_idx[k]]  : '0;
        retire_ctrl[k]    <= ret_sel[k] ? ent_ctrl[ret_idx[k]]    : '0;
        retire_result[k]  <= ret_sel[k] ? ent_result[ret_idx[k]]  : '0;
        retire_wr_data[k] <= ret_sel[k] ? ent_wr_data[ret_idx[k]] : '0;
        if (ret_sel[k]) begin
          ent_valid[ret_idx[k]]   <= 1'b0;
          ent_done[ret_idx[k]]    <= 1'b0;
          ent_pc[ret_idx[k]]      <= '0;
          ent_rd[ret_idx[k]]      <= '0;
          ent_rd_old[ret_idx[k]]  <= '0;
          ent_ctrl[ret_idx[k]]    <= '0;
          ent_result[ret_idx[k]]  <= '0;
          ent_wr_data[ret_idx[k]] <= '0;
        end
      end
      head <= head + ret_n;
    end
  end

endmodule
